// File: rtl/fpu_arith_pkg.sv
// Arithmetic helpers shared by the FPU datapath blocks: operand block partitioning
// used by the conditional sum adder and the borrow-select subtractor.
package fpu_arith_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int num_blocks(input int n, input int k);
        return (n + k - 1) / k;
    endfunction

    function automatic int blk_start(input int s, input int k);
        return s * k;
    endfunction

    // The last block is clipped to the operand width when k does not divide n.
    function automatic int blk_end(input int s, input int n, input int k);
        return (((s + 1) * k) < n) ? ((s + 1) * k - 1) : (n - 1);
    endfunction

    function automatic int blk_size(input int s, input int n, input int k);
        return blk_end(s, n, k) - blk_start(s, k) + 1;
    endfunction

endpackage

// File: rtl/sub_select_block.sv
// W-bit borrow-select cell: both borrow-in outcomes are formed up front and the
// late-arriving borrow only drives the final mux.
module sub_select_block #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] diff0_s;
    logic [W:0] diff1_s;

    // The extra MSB of each (W+1)-bit difference is the block borrow out.
    always_comb begin
        diff0_s = {1'b0, a} - {1'b0, b};
        diff1_s = diff0_s - {{W{1'b0}}, 1'b1};
    end

    assign d    = bin ? diff1_s[W-1:0] : diff0_s[W-1:0];
    assign bout = bin ? diff1_s[W]     : diff0_s[W];

endmodule

// File: rtl/pipelined_borrow_select_subtractor.sv
// Pipelined D = A - B - Bin: one borrow-select block resolved per stage, with a
// valid/ready chain that lets stages fill bubbles while the output is stalled.
module pipelined_borrow_select_subtractor
    import fpu_arith_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] D,
    output logic         Bout,
    output logic         V,
    output logic         Z
);

    localparam int NB = num_blocks(N, K);

    logic [NB-1:0] valid_q;
    logic [NB-1:0] adv_s;
    logic [NB-1:0] load_s;
    logic [NB-1:0] br_q;
    logic [N-1:0]  d_q [NB];
    logic [N-1:0]  a_q [NB];
    logic [N-1:0]  b_q [NB];
    logic [N-1:0]  d_d [NB];
    logic [N-1:0]  a_d [NB];
    logic [N-1:0]  b_d [NB];
    logic          br_d [NB];
    logic          v_q;
    logic          z_q;
    logic          v_d;
    logic          z_d;

    // Advance ripples back from the output so a full pipe can accept and emit together.
    always_comb begin : advance_chain
        logic ripple;
        adv_s        = {NB{1'b0}};
        ripple       = valid_q[NB-1] & out_ready;
        adv_s[NB-1]  = ripple;
        for (int s = NB - 2; s >= 0; s--) begin
            ripple   = valid_q[s] & (~valid_q[s+1] | ripple);
            adv_s[s] = ripple;
        end
    end

    assign in_ready = ~valid_q[0] | adv_s[0];

    always_comb begin
        load_s    = {NB{1'b0}};
        load_s[0] = in_valid & in_ready;
        for (int s = 1; s < NB; s++) begin
            load_s[s] = adv_s[s-1];
        end
    end

    for (genvar s = 0; s < NB; s++) begin : g_stage
        localparam int LO = blk_start(s, K);
        localparam int W  = blk_size(s, N, K);

        logic [N-1:0] a_in;
        logic [N-1:0] b_in;
        logic [N-1:0] d_in;
        logic [N-1:0] d_loc;
        logic         bin_in;
        logic [W-1:0] blk_d;
        logic         blk_b;

        if (s == 0) begin : g_first
            assign a_in   = A;
            assign b_in   = B;
            assign d_in   = {N{1'b0}};
            assign bin_in = Bin;
        end else begin : g_next
            assign a_in   = a_q[s-1];
            assign b_in   = b_q[s-1];
            assign d_in   = d_q[s-1];
            assign bin_in = br_q[s-1];
        end

        sub_select_block #(.W(W)) u_blk (
            .a    (a_in[LO +: W]),
            .b    (b_in[LO +: W]),
            .bin  (bin_in),
            .d    (blk_d),
            .bout (blk_b)
        );

        always_comb begin
            d_loc          = d_in;
            d_loc[LO +: W] = blk_d;
        end

        assign d_d[s]  = d_loc;
        assign a_d[s]  = a_in;
        assign b_d[s]  = b_in;
        assign br_d[s] = blk_b;
    end

    assign v_d = (a_d[NB-1][N-1] ^ b_d[NB-1][N-1]) & (d_d[NB-1][N-1] ^ a_d[NB-1][N-1]);
    assign z_d = (d_d[NB-1] == {N{1'b0}});

    // Stage data only moves on a load, which keeps stalled outputs frozen.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            valid_q <= {NB{1'b0}};
            br_q    <= {NB{1'b0}};
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int s = 0; s < NB; s++) begin
                d_q[s] <= {N{1'b0}};
                a_q[s] <= {N{1'b0}};
                b_q[s] <= {N{1'b0}};
            end
        end else begin
            for (int s = 0; s < NB; s++) begin
                if (load_s[s]) begin
                    valid_q[s] <= 1'b1;
                    d_q[s]     <= d_d[s];
                    a_q[s]     <= a_d[s];
                    b_q[s]     <= b_d[s];
                    br_q[s]    <= br_d[s];
                end else if (adv_s[s]) begin
                    valid_q[s] <= 1'b0;
                end
            end
            if (load_s[NB-1]) begin
                v_q <= v_d;
                z_q <= z_d;
            end
        end
    end

    assign out_valid = valid_q[NB-1];
    assign D         = d_q[NB-1];
    assign Bout      = br_q[NB-1];
    assign V         = v_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_pipelined_borrow_select_subtractor.sv
// Bench for the borrow-select subtractor: a 32-bit and a 30-bit (narrow last block)
// instance checked against an arithmetic reference model and hand-computed vectors.
module tb_pipelined_borrow_select_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    logic        iv32, ir32, ov32, or32, bin32, bout32, v32, z32;
    logic [31:0] a32, b32, d32;
    logic        iv30, ir30, ov30, or30, bin30, bout30, v30, z30;
    logic [29:0] a30, b30, d30;

    pipelined_borrow_select_subtractor #(.N(32), .K(8)) u_dut32 (
        .CLOCK_50(clk), .RESET(rst), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .Bin(bin32), .out_valid(ov32), .out_ready(or32),
        .D(d32), .Bout(bout32), .V(v32), .Z(z32)
    );

    pipelined_borrow_select_subtractor #(.N(30), .K(8)) u_dut30 (
        .CLOCK_50(clk), .RESET(rst), .in_valid(iv30), .in_ready(ir30),
        .A(a30), .B(b30), .Bin(bin30), .out_valid(ov30), .out_ready(or30),
        .D(d30), .Bout(bout30), .V(v30), .Z(z30)
    );

    typedef struct {
        logic [31:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } vec_t;

    res_t q32[$];
    res_t q30[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: plain integer subtraction on n-bit operands.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic bi, input int n);
        res_t   r;
        longint mask, am, bm, diff;
        mask   = (longint'(1) << n) - 1;
        am     = longint'(a) & mask;
        bm     = longint'(b) & mask;
        diff   = am - bm - longint'(bi);
        r.bout = (diff < 0);
        r.d    = 32'(diff & mask);
        r.z    = (r.d == 32'd0);
        r.v    = (a[n-1] != b[n-1]) && (r.d[n-1] != a[n-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Scoreboard: every valid output is checked against the oldest accepted operand set.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ov32) begin
                    if (q32.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious32: out_valid=1 with D=0x%0h, expected no result", d32);
                    end else begin
                        chk("sb32_D", d32, q32[0].d);
                        chk1("sb32_Bout", bout32, q32[0].bout);
                        chk1("sb32_V", v32, q32[0].v);
                        chk1("sb32_Z", z32, q32[0].z);
                        if (or32) void'(q32.pop_front());
                    end
                end
                if (iv32 && ir32) q32.push_back(model(a32, b32, bin32, 32));
                if (ov30) begin
                    if (q30.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL spurious30: out_valid=1 with D=0x%0h, expected no result", d30);
                    end else begin
                        chk("sb30_D", {2'b00, d30}, q30[0].d);
                        chk1("sb30_Bout", bout30, q30[0].bout);
                        chk1("sb30_V", v30, q30[0].v);
                        chk1("sb30_Z", z30, q30[0].z);
                        if (or30) void'(q30.pop_front());
                    end
                end
                if (iv30 && ir30) q30.push_back(model({2'b00, a30}, {2'b00, b30}, bin30, 30));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int which, input logic [31:0] a, input logic [31:0] b,
                        input logic bi, output int waits);
        waits = 0;
        if (which == 32) begin
            iv32 = 1'b1; a32 = a; b32 = b; bin32 = bi;
        end else begin
            iv30 = 1'b1; a30 = a[29:0]; b30 = b[29:0]; bin30 = bi;
        end
        @(negedge clk);
        while (!((which == 32) ? ir32 : ir30) && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        if (which == 32) iv32 = 1'b0;
        else             iv30 = 1'b0;
    endtask

    task automatic run_vec(input int which, input vec_t t, input string tag);
        int w;
        int lat;
        logic [31:0] d_act;
        send(which, t.a, t.b, t.bi, w);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!((which == 32) ? ov32 : ov30) && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        d_act = (which == 32) ? d32 : {2'b00, d30};
        chk({tag, "_D"}, d_act, t.d);
        chk1({tag, "_Bout"}, (which == 32) ? bout32 : bout30, t.bout);
        chk1({tag, "_V"}, (which == 32) ? v32 : v30, t.v);
        chk1({tag, "_Z"}, (which == 32) ? z32 : z30, t.z);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while ((q32.size() != 0 || q30.size() != 0) && g < 40) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk1({tag, "_drained"}, (q32.size() == 0) && (q30.size() == 0), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by 500000 ns, expected an earlier finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs32 [7];
    vec_t vecs30 [2];

    initial begin
        int w;
        vecs32[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
        vecs32[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs32[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs32[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs32[4] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vecs32[5] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
        vecs32[6] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, 1'b0};
        vecs30[0] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h3FFF_FFFF, 1'b1, 1'b0, 1'b0};
        vecs30[1] = '{32'h2AAA_AAAA, 32'h2AAA_AAAA, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        iv32 = 1'b0; a32 = 32'd0; b32 = 32'd0; bin32 = 1'b0; or32 = 1'b1;
        iv30 = 1'b0; a30 = 30'd0; b30 = 30'd0; bin30 = 1'b0; or30 = 1'b1;
        #1;
        chk1("reset_out_valid32", ov32, 1'b0);
        chk("reset_D32", d32, 32'd0);
        chk1("reset_Bout32", bout32, 1'b0);
        chk1("reset_V32", v32, 1'b0);
        chk1("reset_Z32", z32, 1'b0);
        chk1("reset_out_valid30", ov30, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk1("idle_in_ready32", ir32, 1'b1);

        // Directed vectors on the 32-bit instance, then on the narrow-last-block one.
        for (int i = 0; i < 7; i++) run_vec(32, vecs32[i], $sformatf("vec32_%0d", i));
        for (int i = 0; i < 2; i++) run_vec(30, vecs30[i], $sformatf("vec30_%0d", i));

        // Reset with three operand sets in flight.
        for (int i = 0; i < 3; i++) send(32, $urandom, $urandom, 1'($urandom), w);
        rst = 1'b1;
        #1;
        chk1("midreset_out_valid", ov32, 1'b0);
        chk("midreset_D", d32, 32'd0);
        chk1("midreset_Bout", bout32, 1'b0);
        chk1("midreset_Z", z32, 1'b0);
        q32.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("postreset_no_stale", ov32, 1'b0);
        end
        @(posedge clk);
        #1;

        // Back-to-back streaming with out_ready held high.
        for (int i = 0; i < 100; i++) begin
            send(32, $urandom, $urandom, 1'($urandom), w);
            chk("stream_accept_wait", 32'(w), 32'd0);
        end
        drain("stream");

        // Backpressure: out_ready low for six cycles mid-stream.
        fork
            begin
                int w5;
                for (int i = 0; i < 30; i++) send(32, $urandom, $urandom, 1'($urandom), w5);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                or32 = 1'b0;
                repeat (6) @(negedge clk);
                chk1("stall_in_ready", ir32, 1'b0);
                chk1("stall_out_valid", ov32, 1'b1);
                @(posedge clk);
                #1;
                or32 = 1'b1;
            end
        join
        drain("stall");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
